writeback_arbiter: RTL and testbench

Arbitrates completing execution units (alu1, alu2, advint, memunit, branch) onto the two register-file write ports. Each cycle it grants up to two destination writes and acknowledges the winning units. One cycle later it drives the write ports and the `reg1_finished`/`reg2_finished` numbers that the instruction scheduler uses to clear register busy bits.

---
 rtl/writeback_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_writeback_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// writeback_arbiter : grants up to two register-file writes per cycle from five
// execution units. Macro WB_ROUND_ROBIN_EN selects a rotating priority pointer.
// Revision: 1.0
// ============================================================================
module writeback_arbiter #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu1_req,
  input  logic [REG_W-1:0]  alu1_rd,
  input  logic [DATA_W-1:0] alu1_data,
  input  logic              alu2_req,
  input  logic [REG_W-1:0]  alu2_rd,
  input  logic [DATA_W-1:0] alu2_data,
  input  logic              advint_req,
  input  logic [REG_W-1:0]  advint_rd,
  input  logic [DATA_W-1:0] advint_data,
  input  logic [REG_W-1:0]  advint_rd2,
  input  logic [DATA_W-1:0] advint_data2,
  input  logic              memunit_req,
  input  logic [REG_W-1:0]  memunit_rd,
  input  logic [DATA_W-1:0] memunit_data,
  input  logic              branch_req,
  input  logic [REG_W-1:0]  branch_rd,
  input  logic [DATA_W-1:0] branch_data,
  output logic              alu1_ack,
  output logic              alu2_ack,
  output logic              advint_ack,
  output logic              memunit_ack,
  output logic              branch_ack,
  output logic              wb1_en,
  output logic              wb2_en,
  output logic [REG_W-1:0]  wb1_rn,
  output logic [REG_W-1:0]  wb2_rn,
  output logic [DATA_W-1:0] wb1_data,
  output logic [DATA_W-1:0] wb2_data,
  output logic [REG_W-1:0]  reg1_finished,
  output logic [REG_W-1:0]  reg2_finished
);

  localparam int N_REQ = 5;

  logic [N_REQ-1:0]  req_w;
  logic [REG_W-1:0]  rd_w    [N_REQ];
  logic [REG_W-1:0]  rd2_w   [N_REQ];
  logic [DATA_W-1:0] data_w  [N_REQ];
  logic [DATA_W-1:0] data2_w [N_REQ];

  logic [N_REQ-1:0]  grant;
  logic [1:0]        used;
  logic [1:0]        cost;
  logic [2:0]        idx;

  logic              wb1_en_d, wb2_en_d, wb1_en_q, wb2_en_q;
  logic [REG_W-1:0]  wb1_rn_d, wb2_rn_d, wb1_rn_q, wb2_rn_q;
  logic [DATA_W-1:0] wb1_data_d, wb2_data_d, wb1_data_q, wb2_data_q;

  assign req_w = {branch_req, memunit_req, advint_req, alu2_req, alu1_req};

  // Only advint has a second destination; the others see rd2 = 0 so one scan rule fits all.
  always_comb begin
    rd_w[0] = alu1_rd;    data_w[0] = alu1_data;    rd2_w[0] = '0;         data2_w[0] = '0;
    rd_w[1] = alu2_rd;    data_w[1] = alu2_data;    rd2_w[1] = '0;         data2_w[1] = '0;
    rd_w[2] = advint_rd;  data_w[2] = advint_data;  rd2_w[2] = advint_rd2; data2_w[2] = advint_data2;
    rd_w[3] = memunit_rd; data_w[3] = memunit_data; rd2_w[3] = '0;         data2_w[3] = '0;
    rd_w[4] = branch_rd;  data_w[4] = branch_data;  rd2_w[4] = '0;         data2_w[4] = '0;
  end

`ifdef WB_ROUND_ROBIN_EN
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] last;

  function automatic logic [2:0] scan_idx(input logic [2:0] k, input logic [2:0] base);
    logic [3:0] s;
    s = {1'b0, base} + {1'b0, k};
    if (s >= 4'd5) s = s - 4'd5;
    return s[2:0];
  endfunction
`else
  function automatic logic [2:0] scan_idx(input logic [2:0] k);
    case (k)
      3'd0:    return 3'd4;
      3'd1:    return 3'd3;
      3'd2:    return 3'd2;
      3'd3:    return 3'd0;
      default: return 3'd1;
    endcase
  endfunction
`endif

  always_comb begin
    grant      = '0;
    used       = '0;
    cost       = '0;
    idx        = '0;
    wb1_en_d   = 1'b0;
    wb1_rn_d   = '0;
    wb1_data_d = '0;
    wb2_en_d   = 1'b0;
    wb2_rn_d   = '0;
    wb2_data_d = '0;
`ifdef WB_ROUND_ROBIN_EN
    last       = ptr_q;
`endif
    for (int k = 0; k < N_REQ; k++) begin
`ifdef WB_ROUND_ROBIN_EN
      idx = scan_idx(3'(k), ptr_q);
`else
      idx = scan_idx(3'(k));
`endif
      cost = {1'b0, rd_w[idx] != '0} + {1'b0, rd2_w[idx] != '0};
      // Whole-cost fit only: a two-slot advint is never split across cycles.
      if (req_w[idx] && (({1'b0, used} + {1'b0, cost}) <= 3'd2)) begin
        grant[idx] = 1'b1;
`ifdef WB_ROUND_ROBIN_EN
        last = idx;
`endif
        if (rd_w[idx] != '0) begin
          if (used == 2'd0) begin
            wb1_en_d = 1'b1; wb1_rn_d = rd_w[idx]; wb1_data_d = data_w[idx];
          end else begin
            wb2_en_d = 1'b1; wb2_rn_d = rd_w[idx]; wb2_data_d = data_w[idx];
          end
          used = used + 2'd1;
        end
        if (rd2_w[idx] != '0) begin
          if (used == 2'd0) begin
            wb1_en_d = 1'b1; wb1_rn_d = rd2_w[idx]; wb1_data_d = data2_w[idx];
          end else begin
            wb2_en_d = 1'b1; wb2_rn_d = rd2_w[idx]; wb2_data_d = data2_w[idx];
          end
          used = used + 2'd1;
        end
      end
    end
`ifdef WB_ROUND_ROBIN_EN
    ptr_d = ptr_q;
    if (grant != '0) ptr_d = (last == 3'd4) ? 3'd0 : last + 3'd1;
`endif
  end

  assign {branch_ack, memunit_ack, advint_ack, alu2_ack, alu1_ack} = grant & {N_REQ{rst_n}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb1_en_q   <= 1'b0;
      wb1_rn_q   <= '0;
      wb1_data_q <= '0;
      wb2_en_q   <= 1'b0;
      wb2_rn_q   <= '0;
      wb2_data_q <= '0;
    end else begin
      wb1_en_q   <= wb1_en_d;
      wb1_rn_q   <= wb1_rn_d;
      wb1_data_q <= wb1_data_d;
      wb2_en_q   <= wb2_en_d;
      wb2_rn_q   <= wb2_rn_d;
      wb2_data_q <= wb2_data_d;
    end
  end

`ifdef WB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 3'd0;
    else        ptr_q <= ptr_d;
  end
`endif

  assign wb1_en        = wb1_en_q;
  assign wb2_en        = wb2_en_q;
  assign wb1_rn        = wb1_rn_q;
  assign wb2_rn        = wb2_rn_q;
  assign wb1_data      = wb1_data_q;
  assign wb2_data      = wb2_data_q;
  assign reg1_finished = wb1_en_q ? wb1_rn_q : '0;
  assign reg2_finished = wb2_en_q ? wb2_rn_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// tb_writeback_arbiter : directed self-checking bench for writeback_arbiter.
// Revision: 1.0
// ============================================================================
module tb_writeback_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic alu1_req, alu2_req, advint_req, memunit_req, branch_req;
  logic [5:0]  alu1_rd, alu2_rd, advint_rd, advint_rd2, memunit_rd, branch_rd;
  logic [63:0] alu1_data, alu2_data, advint_data, advint_data2, memunit_data, branch_data;
  logic alu1_ack, alu2_ack, advint_ack, memunit_ack, branch_ack;
  logic wb1_en, wb2_en;
  logic [5:0]  wb1_rn, wb2_rn, reg1_finished, reg2_finished;
  logic [63:0] wb1_data, wb2_data;

  logic [4:0]  acks;
  logic [76:0] p1, p2;
  int n_checks = 0;
  int n_fail = 0;

  assign acks = {branch_ack, memunit_ack, advint_ack, alu2_ack, alu1_ack};
  assign p1   = {wb1_en, wb1_rn, wb1_data, reg1_finished};
  assign p2   = {wb2_en, wb2_rn, wb2_data, reg2_finished};

  always #5 clk = ~clk;

  writeback_arbiter #(.DATA_W(64), .REG_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu1_req(alu1_req), .alu1_rd(alu1_rd), .alu1_data(alu1_data),
    .alu2_req(alu2_req), .alu2_rd(alu2_rd), .alu2_data(alu2_data),
    .advint_req(advint_req), .advint_rd(advint_rd), .advint_data(advint_data),
    .advint_rd2(advint_rd2), .advint_data2(advint_data2),
    .memunit_req(memunit_req), .memunit_rd(memunit_rd), .memunit_data(memunit_data),
    .branch_req(branch_req), .branch_rd(branch_rd), .branch_data(branch_data),
    .alu1_ack(alu1_ack), .alu2_ack(alu2_ack), .advint_ack(advint_ack),
    .memunit_ack(memunit_ack), .branch_ack(branch_ack),
    .wb1_en(wb1_en), .wb2_en(wb2_en), .wb1_rn(wb1_rn), .wb2_rn(wb2_rn),
    .wb1_data(wb1_data), .wb2_data(wb2_data),
    .reg1_finished(reg1_finished), .reg2_finished(reg2_finished)
  );

  // Expected write-port tuple {en, rn, data, finished} for an enabled port.
  function automatic logic [76:0] wb(input logic [5:0] rn, input logic [63:0] d);
    return {1'b1, rn, d, rn};
  endfunction

  task automatic clear_all();
    alu1_req = 0; alu1_rd = 0; alu1_data = 0;
    alu2_req = 0; alu2_rd = 0; alu2_data = 0;
    advint_req = 0; advint_rd = 0; advint_data = 0; advint_rd2 = 0; advint_data2 = 0;
    memunit_req = 0; memunit_rd = 0; memunit_data = 0;
    branch_req = 0; branch_rd = 0; branch_data = 0;
  endtask

  task automatic do_reset();
    clear_all();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_all();
    rst_n = 1'b0;
    alu1_req = 1; alu1_rd = 6'd1; alu1_data = 64'h1;
    @(negedge clk); #1;
    n_checks++; if (acks !== 5'b0) begin n_fail++; $display("FAIL reset_ack got=%b exp=%b", acks, 5'b0); end
    n_checks++; if (p1 !== 77'd0) begin n_fail++; $display("FAIL reset_p1 got=%h exp=0", p1); end
    n_checks++; if (p2 !== 77'd0) begin n_fail++; $display("FAIL reset_p2 got=%h exp=0", p2); end
    clear_all();
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    alu1_req = 1; alu1_rd = 6'd5; alu1_data = 64'h1234;
    #1;
    n_checks++; if (acks !== 5'b00001) begin n_fail++; $display("FAIL single_ack got=%b exp=%b", acks, 5'b00001); end
    @(posedge clk); #1; clear_all();
    n_checks++; if (p1 !== wb(6'd5, 64'h1234)) begin n_fail++; $display("FAIL single_p1 got=%h exp=%h", p1, wb(6'd5, 64'h1234)); end
    n_checks++; if (p2 !== 77'd0) begin n_fail++; $display("FAIL single_p2 got=%h exp=0", p2); end
    @(posedge clk); #1;
    n_checks++; if (p1 !== 77'd0) begin n_fail++; $display("FAIL single_p1_next got=%h exp=0", p1); end
  endtask

  task automatic test_contention();
    logic [4:0]  ea1, ea2;
    logic [76:0] e11, e12, e21;
`ifdef WB_ROUND_ROBIN_EN
    ea1 = 5'b00011; e11 = wb(6'd1, 64'h11); e12 = wb(6'd2, 64'h22);
    ea2 = 5'b01000; e21 = wb(6'd3, 64'h33);
`else
    ea1 = 5'b01001; e11 = wb(6'd3, 64'h33); e12 = wb(6'd1, 64'h11);
    ea2 = 5'b00010; e21 = wb(6'd2, 64'h22);
`endif
    do_reset();
    @(negedge clk);
    alu1_req = 1; alu1_rd = 6'd1; alu1_data = 64'h11;
    alu2_req = 1; alu2_rd = 6'd2; alu2_data = 64'h22;
    memunit_req = 1; memunit_rd = 6'd3; memunit_data = 64'h33;
    #1;
    n_checks++; if (acks !== ea1) begin n_fail++; $display("FAIL cont_ack1 got=%b exp=%b", acks, ea1); end
    @(posedge clk); #1;
    if (ea1[0]) alu1_req = 0;
    if (ea1[1]) alu2_req = 0;
    if (ea1[3]) memunit_req = 0;
    n_checks++; if (p1 !== e11) begin n_fail++; $display("FAIL cont_p1 got=%h exp=%h", p1, e11); end
    n_checks++; if (p2 !== e12) begin n_fail++; $display("FAIL cont_p2 got=%h exp=%h", p2, e12); end
    @(negedge clk); #1;
    n_checks++; if (acks !== ea2) begin n_fail++; $display("FAIL cont_ack2 got=%b exp=%b", acks, ea2); end
    @(posedge clk); #1; clear_all();
    n_checks++; if (p1 !== e21) begin n_fail++; $display("FAIL cont_p1b got=%h exp=%h", p1, e21); end
    n_checks++; if (p2 !== 77'd0) begin n_fail++; $display("FAIL cont_p2b got=%h exp=0", p2); end
    // Rotated priority now starts at branch: branch and alu1 win, alu2 waits.
    @(negedge clk);
    alu1_req = 1; alu1_rd = 6'd1; alu1_data = 64'h11;
    alu2_req = 1; alu2_rd = 6'd2; alu2_data = 64'h22;
    branch_req = 1; branch_rd = 6'd5; branch_data = 64'h55;
    #1;
    n_checks++; if (acks !== 5'b10001) begin n_fail++; $display("FAIL cont_ack3 got=%b exp=%b", acks, 5'b10001); end
    @(posedge clk); #1; alu1_req = 0; branch_req = 0;
    n_checks++; if (p1 !== wb(6'd5, 64'h55)) begin n_fail++; $display("FAIL cont_p1c got=%h exp=%h", p1, wb(6'd5, 64'h55)); end
    n_checks++; if (p2 !== wb(6'd1, 64'h11)) begin n_fail++; $display("FAIL cont_p2c got=%h exp=%h", p2, wb(6'd1, 64'h11)); end
    @(negedge clk); #1;
    n_checks++; if (acks !== 5'b00010) begin n_fail++; $display("FAIL cont_ack4 got=%b exp=%b", acks, 5'b00010); end
    @(posedge clk); #1; clear_all();
  endtask

  task automatic test_advint_dual();
    do_reset();
    @(negedge clk);
    alu2_req = 1; alu2_rd = 6'd2; alu2_data = 64'h22;
    #1;
    n_checks++; if (acks !== 5'b00010) begin n_fail++; $display("FAIL dual_pre_ack got=%b exp=%b", acks, 5'b00010); end
    @(posedge clk); #1; clear_all();
    @(negedge clk);
    advint_req = 1; advint_rd = 6'd3; advint_data = 64'hAAAA; advint_rd2 = 6'd4; advint_data2 = 64'hBBBB;
    alu1_req = 1; alu1_rd = 6'd7; alu1_data = 64'h77;
    #1;
    n_checks++; if (acks !== 5'b00100) begin n_fail++; $display("FAIL dual_ack got=%b exp=%b", acks, 5'b00100); end
    @(posedge clk); #1; advint_req = 0;
    n_checks++; if (p1 !== wb(6'd3, 64'hAAAA)) begin n_fail++; $display("FAIL dual_p1 got=%h exp=%h", p1, wb(6'd3, 64'hAAAA)); end
    n_checks++; if (p2 !== wb(6'd4, 64'hBBBB)) begin n_fail++; $display("FAIL dual_p2 got=%h exp=%h", p2, wb(6'd4, 64'hBBBB)); end
    @(negedge clk); #1;
    n_checks++; if (acks !== 5'b00001) begin n_fail++; $display("FAIL dual_ack2 got=%b exp=%b", acks, 5'b00001); end
    @(posedge clk); #1; clear_all();
    n_checks++; if (p1 !== wb(6'd7, 64'h77)) begin n_fail++; $display("FAIL dual_p1b got=%h exp=%h", p1, wb(6'd7, 64'h77)); end
  endtask

  task automatic test_advint_nofit();
    logic [4:0]  ea1, ea2;
    logic [76:0] e11, e12, e21, e22;
`ifdef WB_ROUND_ROBIN_EN
    ea1 = 5'b00011; e11 = wb(6'd5, 64'h55); e12 = wb(6'd6, 64'h66);
    ea2 = 5'b00100; e21 = wb(6'd3, 64'hA3); e22 = wb(6'd4, 64'hA4);
`else
    ea1 = 5'b00100; e11 = wb(6'd3, 64'hA3); e12 = wb(6'd4, 64'hA4);
    ea2 = 5'b00011; e21 = wb(6'd5, 64'h55); e22 = wb(6'd6, 64'h66);
`endif
    do_reset();
    @(negedge clk);
    advint_req = 1; advint_rd = 6'd3; advint_data = 64'hA3; advint_rd2 = 6'd4; advint_data2 = 64'hA4;
    alu1_req = 1; alu1_rd = 6'd5; alu1_data = 64'h55;
    alu2_req = 1; alu2_rd = 6'd6; alu2_data = 64'h66;
    #1;
    n_checks++; if (acks !== ea1) begin n_fail++; $display("FAIL nofit_ack1 got=%b exp=%b", acks, ea1); end
    @(posedge clk); #1;
    if (ea1[0]) alu1_req = 0;
    if (ea1[1]) alu2_req = 0;
    if (ea1[2]) advint_req = 0;
    n_checks++; if (p1 !== e11) begin n_fail++; $display("FAIL nofit_p1 got=%h exp=%h", p1, e11); end
    n_checks++; if (p2 !== e12) begin n_fail++; $display("FAIL nofit_p2 got=%h exp=%h", p2, e12); end
    @(negedge clk); #1;
    n_checks++; if (acks !== ea2) begin n_fail++; $display("FAIL nofit_ack2 got=%b exp=%b", acks, ea2); end
    @(posedge clk); #1; clear_all();
    n_checks++; if (p1 !== e21) begin n_fail++; $display("FAIL nofit_p1b got=%h exp=%h", p1, e21); end
    n_checks++; if (p2 !== e22) begin n_fail++; $display("FAIL nofit_p2b got=%h exp=%h", p2, e22); end
  endtask

  task automatic test_zero_dest();
    logic [76:0] e1, e2;
`ifdef WB_ROUND_ROBIN_EN
    e1 = wb(6'd10, 64'h100); e2 = wb(6'd8, 64'h88);
`else
    e1 = wb(6'd8, 64'h88); e2 = wb(6'd10, 64'h100);
`endif
    do_reset();
    @(negedge clk);
    memunit_req = 1; memunit_rd = 6'd0; memunit_data = 64'hDEAD;
    alu1_req = 1; alu1_rd = 6'd9; alu1_data = 64'h99;
    #1;
    n_checks++; if (acks !== 5'b01001) begin n_fail++; $display("FAIL zero_ack got=%b exp=%b", acks, 5'b01001); end
    @(posedge clk); #1; clear_all();
    n_checks++; if (p1 !== wb(6'd9, 64'h99)) begin n_fail++; $display("FAIL zero_p1 got=%h exp=%h", p1, wb(6'd9, 64'h99)); end
    n_checks++; if (p2 !== 77'd0) begin n_fail++; $display("FAIL zero_p2 got=%h exp=0", p2); end
    @(negedge clk);
    advint_req = 1; advint_rd = 6'd0; advint_data = 64'hBAD; advint_rd2 = 6'd8; advint_data2 = 64'h88;
    alu2_req = 1; alu2_rd = 6'd10; alu2_data = 64'h100;
    #1;
    n_checks++; if (acks !== 5'b00110) begin n_fail++; $display("FAIL zero_rd2_ack got=%b exp=%b", acks, 5'b00110); end
    @(posedge clk); #1; clear_all();
    n_checks++; if (p1 !== e1) begin n_fail++; $display("FAIL zero_rd2_p1 got=%h exp=%h", p1, e1); end
    n_checks++; if (p2 !== e2) begin n_fail++; $display("FAIL zero_rd2_p2 got=%h exp=%h", p2, e2); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    alu1_req = 1; alu1_rd = 6'd11; alu1_data = 64'hA;
    #1;
    n_checks++; if (acks !== 5'b00001) begin n_fail++; $display("FAIL b2b_ack1 got=%b exp=%b", acks, 5'b00001); end
    @(posedge clk); #1;
    alu1_rd = 6'd12; alu1_data = 64'hB;
    n_checks++; if (p1 !== wb(6'd11, 64'hA)) begin n_fail++; $display("FAIL b2b_p1a got=%h exp=%h", p1, wb(6'd11, 64'hA)); end
    @(negedge clk); #1;
    n_checks++; if (acks !== 5'b00001) begin n_fail++; $display("FAIL b2b_ack2 got=%b exp=%b", acks, 5'b00001); end
    @(posedge clk); #1; clear_all();
    n_checks++; if (p1 !== wb(6'd12, 64'hB)) begin n_fail++; $display("FAIL b2b_p1b got=%h exp=%h", p1, wb(6'd12, 64'hB)); end
  endtask

  task automatic test_reset_mid();
    logic [4:0]  ea;
    logic [76:0] e1, e2;
`ifdef WB_ROUND_ROBIN_EN
    ea = 5'b00011; e1 = wb(6'd5, 64'h55); e2 = wb(6'd6, 64'h66);
`else
    ea = 5'b10001; e1 = wb(6'd8, 64'h88); e2 = wb(6'd5, 64'h55);
`endif
    do_reset();
    @(negedge clk);
    alu2_req = 1; alu2_rd = 6'd6; alu2_data = 64'h66;
    memunit_req = 1; memunit_rd = 6'd7; memunit_data = 64'h77;
    @(posedge clk); #1;
    n_checks++; if (p1[76] !== 1'b1) begin n_fail++; $display("FAIL mid_pre_en got=%b exp=1", p1[76]); end
    memunit_req = 0;
    alu1_req = 1; alu1_rd = 6'd5; alu1_data = 64'h55;
    branch_req = 1; branch_rd = 6'd8; branch_data = 64'h88;
    rst_n = 1'b0;
    #1;
    n_checks++; if (acks !== 5'b0) begin n_fail++; $display("FAIL mid_ack got=%b exp=%b", acks, 5'b0); end
    n_checks++; if (p1 !== 77'd0) begin n_fail++; $display("FAIL mid_p1 got=%h exp=0", p1); end
    n_checks++; if (p2 !== 77'd0) begin n_fail++; $display("FAIL mid_p2 got=%h exp=0", p2); end
    @(posedge clk); #1;
    n_checks++; if (acks !== 5'b0) begin n_fail++; $display("FAIL mid_ack_held got=%b exp=%b", acks, 5'b0); end
    @(negedge clk); rst_n = 1'b1;
    #1;
    n_checks++; if (acks !== ea) begin n_fail++; $display("FAIL mid_rel_ack got=%b exp=%b", acks, ea); end
    @(posedge clk); #1; clear_all();
    n_checks++; if (p1 !== e1) begin n_fail++; $display("FAIL mid_rel_p1 got=%h exp=%h", p1, e1); end
    n_checks++; if (p2 !== e2) begin n_fail++; $display("FAIL mid_rel_p2 got=%h exp=%h", p2, e2); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_advint_dual();
    test_advint_nofit();
    test_zero_dest();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
